// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: pixel-clock input and timing outputs of the VGA sync generator
//   pixel_clk    divided pixel clock, sampled as data by the generator
//   hsync/vsync  registered sync outputs
//   video_on     visible-area flag for the renderer
//   pixel_x/y    current counter position
//   frame_start  one-clk pulse on entering (0,0)
//   master: drives pixel_clk and observes timing; slave: the generator itself
interface vga_sync_gen_if #(
    parameter int CW = 10
);
    logic          pixel_clk;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          frame_start;

    modport master (
        output pixel_clk,
        input  hsync, vsync, video_on, pixel_x, pixel_y, frame_start
    );

    modport slave (
        input  pixel_clk,
        output hsync, vsync, video_on, pixel_x, pixel_y, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA horizontal/vertical timing generator in the clk domain
//   clk  system clock
//   rst  synchronous reset, active-low
//   vga  slave side of vga_sync_gen_if (pixel_clk in; hsync, vsync, video_on,
//        pixel_x, pixel_y, frame_start out)
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0,
    parameter int CW        = 10
) (
    input logic         clk,
    input logic         rst,
    vga_sync_gen_if.slave vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS  = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS  = CW'(V_VISIBLE);
    localparam logic [CW-1:0] H_SS   = CW'(H_VISIBLE + H_FP);
    localparam logic [CW-1:0] H_SE   = CW'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] V_SS   = CW'(V_VISIBLE + V_FP);
    localparam logic [CW-1:0] V_SE   = CW'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic          pclk_q;
    logic          tick_q;
    logic [CW-1:0] x, y, nx, ny;
    logic          hs_n, vs_n, von_n;
    logic          hsync_q, vsync_q, von_q, fs_q;

    // Outputs are decoded from the next position so that every registered
    // output refers to the same (x,y) as the counters after the update.
    always_comb begin
        nx    = (x == H_LAST) ? '0 : x + 1'b1;
        ny    = (x != H_LAST) ? y : (y == V_LAST) ? '0 : y + 1'b1;
        hs_n  = (nx >= H_SS && nx <= H_SE) ? SYNC_POL : ~SYNC_POL;
        vs_n  = (ny >= V_SS && ny <= V_SE) ? SYNC_POL : ~SYNC_POL;
        von_n = (nx < H_VIS) && (ny < V_VIS);
    end

    // The rising edge of pixel_clk is captured into tick_q on one clk edge
    // and the counters/outputs move on the following edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pclk_q      <= 1'b0;
            tick_q      <= 1'b0;
            x           <= H_LAST;
            y           <= V_LAST;
            hsync_q     <= ~SYNC_POL;
            vsync_q     <= ~SYNC_POL;
            von_q       <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            pclk_q      <= vga.pixel_clk;
            tick_q      <= vga.pixel_clk & ~pclk_q;
            fs_q        <= tick_q && (nx == '0) && (ny == '0);
            if (tick_q) begin
                x       <= nx;
                y       <= ny;
                hsync_q <= hs_n;
                vsync_q <= vs_n;
                von_q   <= von_n;
            end
        end
    end

    assign vga.pixel_x     = x;
    assign vga.pixel_y     = y;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = von_q;
    assign vga.frame_start = fs_q;
endmodule
